exec_dispatch: RTL and testbench



---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/op_decode.sv | 34 +++
 rtl/exec_dispatch.sv | 181 ++++++++++++++++++
 tb/tb_exec_dispatch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg                                                          |
// | Shared CPU constants: opcodes, one-hot FSM selects, 4-bit enable |
// | constants, booleans and the execute dispatcher state encoding.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package cpu_pkg;

   // Instruction opcodes (0000, 1110 and 1111 are illegal)
   localparam logic [3:0] paraAdd   = 4'b0001;
   localparam logic [3:0] paraSub   = 4'b0010;
   localparam logic [3:0] paraAnd   = 4'b0011;
   localparam logic [3:0] paraOr    = 4'b0100;
   localparam logic [3:0] paraXor   = 4'b0101;
   localparam logic [3:0] paraCmp   = 4'b0110;
   localparam logic [3:0] paraNot   = 4'b0111;
   localparam logic [3:0] paraInc   = 4'b1000;
   localparam logic [3:0] paraDec   = 4'b1001;
   localparam logic [3:0] paraMov   = 4'b1010;
   localparam logic [3:0] paraMovi  = 4'b1011;
   localparam logic [3:0] paraLoad  = 4'b1100;
   localparam logic [3:0] paraStore = 4'b1101;

   // One-hot execution FSM selects on the nextFSM bus
   localparam logic [6:0] stateBlank   = 7'b0000000;
   localparam logic [6:0] stateAluPar2 = 7'b0000001;
   localparam logic [6:0] stateAluPar1 = 7'b0000010;
   localparam logic [6:0] stateAluNot  = 7'b0000100;
   localparam logic [6:0] stateMove    = 7'b0001000;
   localparam logic [6:0] stateMovi    = 7'b0010000;
   localparam logic [6:0] stateLoad    = 7'b0100000;
   localparam logic [6:0] stateStore   = 7'b1000000;
   localparam logic [6:0] stateError   = 7'b1111111;

   // Four-bit register enable constants
   localparam logic [3:0] fourBlank = 4'b0000;
   localparam logic [3:0] fourError = 4'b1111;

   localparam logic true  = 1'b1;
   localparam logic false = 1'b0;

   // Execute dispatcher states
   typedef enum logic [2:0] {
      DS_IDLE   = 3'd0,
      DS_LAUNCH = 3'd1,
      DS_BLANK  = 3'd2,
      DS_WAIT   = 3'd3,
      DS_RETIRE = 3'd4,
      DS_ERROR  = 3'd5
   } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/op_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | op_decode                                                        |
// | Combinational opcode decoder: 4-bit opcode to one-hot execution  |
// | FSM select plus an illegal-opcode flag. Shared with fetch.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module op_decode
   import cpu_pkg::*;
(
   input  logic [3:0] opCode,
   output logic [6:0] sel,
   output logic       illegal
);

   // Opcode classification; anything unlisted is illegal with a blank select
   always_comb begin
      sel     = stateBlank;
      illegal = false;
      case (opCode)
         paraAdd, paraSub, paraAnd,
         paraOr, paraXor, paraCmp: sel = stateAluPar2;
         paraInc, paraDec:         sel = stateAluPar1;
         paraNot:                  sel = stateAluNot;
         paraMov:                  sel = stateMove;
         paraMovi:                 sel = stateMovi;
         paraLoad:                 sel = stateLoad;
         paraStore:                sel = stateStore;
         default:                  illegal = true;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/exec_dispatch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | exec_dispatch                                                    |
// | Execute-stage scheduler: launches one execution FSM per decoded  |
// | instruction, masks stale done flags, waits for done, retires,    |
// | and forwards the active FSM's register enables with conflict     |
// | detection.                                                       |
// | Optional: DISPATCH_WATCHDOG_EN enables the WAIT timeout.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module exec_dispatch
   import cpu_pkg::*;
#(
   parameter int BLANK_CYC = 2,
   parameter int TIMEOUT   = 64,
   parameter int CNT_W     = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       insValid,
   input  logic [3:0] opCode,
   input  logic       resAlu,
   input  logic       resMov,
   input  logic       resMovi,
   input  logic       resLoad,
   input  logic       resStore,
   input  logic [3:0] wERalu,
   input  logic [3:0] wERmov,
   input  logic [3:0] wERmovi,
   input  logic [3:0] wERload,
   input  logic [3:0] wERstore,
   input  logic [3:0] rERalu,
   input  logic [3:0] rERmov,
   input  logic [3:0] rERmovi,
   input  logic [3:0] rERload,
   input  logic [3:0] rERstore,
   output logic       insReady,
   output logic [6:0] nextFSM,
   output logic [3:0] wER,
   output logic [3:0] rER,
   output logic       insDone,
   output logic       errFlag
);

   // Counter only needs to cover the blank window unless the watchdog is built
`ifdef DISPATCH_WATCHDOG_EN
   localparam int CW = CNT_W;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
`else
   localparam int CW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
`endif
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   // Elaboration-time sanity of the configuration
   if (BLANK_CYC < 1 || (1 << CNT_W) <= TIMEOUT) begin : g_bad_cfg
      $error("exec_dispatch: BLANK_CYC must be >= 1 and 2**CNT_W > TIMEOUT");
   end

   disp_state_t   state_q, state_d;
   logic [6:0]    sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    wer_q, wer_d;
   logic [3:0]    rer_q, rer_d;

   logic [6:0]    dec_sel;
   logic          dec_illegal;
   logic [4:0]    fsm_act;
   logic [4:0]    fsm_busy;
   logic [4:0]    fsm_res;
   logic [3:0]    sel_w;
   logic [3:0]    sel_r;
   logic          bus_err;
   logic          done_sel;

   op_decode u_op_decode (
      .opCode  (opCode),
      .sel     (dec_sel),
      .illegal (dec_illegal)
   );

   // Per-FSM view {store, load, movi, mov, alu}; the three ALU selects share one FSM
   assign fsm_act  = {sel_q[6], sel_q[5], sel_q[4], sel_q[3], |sel_q[2:0]};
   assign fsm_busy = {(|wERstore) | (|rERstore), (|wERload) | (|rERload),
                      (|wERmovi)  | (|rERmovi),  (|wERmov)  | (|rERmov),
                      (|wERalu)   | (|rERalu)};
   assign fsm_res  = {resStore, resLoad, resMovi, resMov, resAlu};

   assign sel_w = ({4{fsm_act[0]}} & wERalu)  | ({4{fsm_act[1]}} & wERmov) |
                  ({4{fsm_act[2]}} & wERmovi) | ({4{fsm_act[3]}} & wERload) |
                  ({4{fsm_act[4]}} & wERstore);
   assign sel_r = ({4{fsm_act[0]}} & rERalu)  | ({4{fsm_act[1]}} & rERmov) |
                  ({4{fsm_act[2]}} & rERmovi) | ({4{fsm_act[3]}} & rERload) |
                  ({4{fsm_act[4]}} & rERstore);

   // A foreign FSM touching the bus, or the active one driving all-ones, is fatal
   assign bus_err  = (|(fsm_busy & ~fsm_act)) | (sel_w == fourError) | (sel_r == fourError);
   assign done_sel = |(fsm_act & fsm_res);

   // Next-state, select latch, blank/timeout counter and enable forwarding
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      case (state_q)
         DS_IDLE: begin
            if (insValid) begin
               sel_d   = dec_sel;
               state_d = dec_illegal ? DS_ERROR : DS_LAUNCH;
            end
         end
         DS_LAUNCH: begin
            cnt_d   = '0;
            state_d = DS_BLANK;
         end
         DS_BLANK: begin
            if (bus_err) begin
               state_d = DS_ERROR;
            end else if (cnt_q == BLANK_LAST) begin
               cnt_d   = '0;
               state_d = DS_WAIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DS_WAIT: begin
            // Error beats done; done beats watchdog expiry
            if (bus_err) begin
               state_d = DS_ERROR;
            end else if (done_sel) begin
               state_d = DS_RETIRE;
            end
`ifdef DISPATCH_WATCHDOG_EN
            else if (cnt_q == TO_LAST) begin
               state_d = DS_ERROR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         DS_RETIRE: state_d = DS_IDLE;
         DS_ERROR:  state_d = DS_ERROR;
         default:   state_d = DS_ERROR;
      endcase

      // Enables are shown one cycle late while an instruction is in flight
      if (state_d == DS_BLANK || state_d == DS_WAIT || state_d == DS_RETIRE) begin
         wer_d = sel_w;
         rer_d = sel_r;
      end else begin
         wer_d = fourBlank;
         rer_d = fourBlank;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DS_IDLE;
         sel_q   <= stateBlank;
         cnt_q   <= '0;
         wer_q   <= fourBlank;
         rer_q   <= fourBlank;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         wer_q   <= wer_d;
         rer_q   <= rer_d;
      end
   end

   assign nextFSM  = (state_q == DS_LAUNCH) ? sel_q :
                     (state_q == DS_ERROR)  ? stateError : stateBlank;
   assign insReady = (state_q == DS_IDLE);
   assign insDone  = (state_q == DS_RETIRE);
   assign errFlag  = (state_q == DS_ERROR);
   assign wER      = wer_q;
   assign rER      = rer_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_dispatch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_exec_dispatch                                                 |
// | Self-checking bench for exec_dispatch: directed scenarios plus   |
// | randomized instruction streams against a cycle-offset model.     |
// | Optional: DISPATCH_WATCHDOG_EN selects the watchdog scenario.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_exec_dispatch;

   localparam int BLANK = 2;
`ifdef DISPATCH_WATCHDOG_EN
   localparam int TO = 8;
`else
   localparam int TO = 64;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       insValid;
   logic [3:0] opCode;
   logic [3:0] wer_in [5];
   logic [3:0] rer_in [5];
   logic       res_in [5];
   logic       insReady, insDone, errFlag;
   logic [6:0] nextFSM;
   logic [3:0] wER, rER;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exec_dispatch #(.BLANK_CYC(BLANK), .TIMEOUT(TO), .CNT_W(7)) dut (
      .clk(clk), .rst(rst), .insValid(insValid), .opCode(opCode),
      .resAlu(res_in[0]), .resMov(res_in[1]), .resMovi(res_in[2]),
      .resLoad(res_in[3]), .resStore(res_in[4]),
      .wERalu(wer_in[0]), .wERmov(wer_in[1]), .wERmovi(wer_in[2]),
      .wERload(wer_in[3]), .wERstore(wer_in[4]),
      .rERalu(rer_in[0]), .rERmov(rer_in[1]), .rERmovi(rer_in[2]),
      .rERload(rer_in[3]), .rERstore(rer_in[4]),
      .insReady(insReady), .nextFSM(nextFSM), .wER(wER), .rER(rER),
      .insDone(insDone), .errFlag(errFlag)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference opcode map
   function automatic logic [6:0] ref_sel(input logic [3:0] op);
      if (op >= 4'd1 && op <= 4'd6) return 7'b0000001;
      if (op == 4'd8 || op == 4'd9) return 7'b0000010;
      if (op == 4'd7)               return 7'b0000100;
      if (op >= 4'd10 && op <= 4'd13) return 7'(1 << (op - 4'd7));
      return 7'b0000000;
   endfunction

   // Index into the bench's {alu, mov, movi, load, store} arrays
   function automatic int ref_idx(input logic [3:0] op);
      return (op <= 4'd9) ? 0 : int'(op) - 9;
   endfunction

   function automatic logic [3:0] rand_bus();
      return ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_quiet();
      for (int i = 0; i < 5; i++) begin
         wer_in[i] = 4'b0000;
         rer_in[i] = 4'b0000;
         res_in[i] = 1'b0;
      end
   endtask

   task automatic drive(input int idx, input logic done);
      drive_quiet();
      wer_in[idx] = rand_bus();
      rer_in[idx] = rand_bus();
      res_in[idx] = done;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      insValid = 1'b0;
      drive_quiet();
      tick();
      chk("rst_nextFSM", nextFSM, 7'b0000000);
      chk("rst_wER", wER, 4'b0000);
      chk("rst_rER", rER, 4'b0000);
      chk("rst_insDone", insDone, 1'b0);
      chk("rst_errFlag", errFlag, 1'b0);
      chk("rst_insReady", insReady, 1'b1);
      rst = 1'b0;
   endtask

   // Accept op, then advance until the cycle numbered upto (1 = launch cycle)
   task automatic launch(input logic [3:0] op, input int upto);
      insValid = 1'b1;
      opCode   = op;
      drive(ref_idx(op), 1'b0);
      tick();
      insValid = 1'b0;
      for (int k = 1; k < upto; k++) begin
         drive(ref_idx(op), 1'b0);
         tick();
      end
   endtask

   // Full instruction with done arriving dly cycles into WAIT; every cycle checked
   task automatic run_instr(input logic [3:0] op, input int dly);
      int         idx;
      int         ret;
      logic [6:0] exp_sel;
      logic [3:0] pw, pr;
      logic       dn;
      idx     = ref_idx(op);
      exp_sel = ref_sel(op);
      ret     = 3 + BLANK + dly;
      chk("ready_before", insReady, 1'b1);
      insValid = 1'b1;
      opCode   = op;
      drive(idx, 1'b0);
      tick();
      insValid = 1'b0;
      opCode   = 4'($urandom);
      pw = 4'b0000;
      pr = 4'b0000;
      for (int k = 1; k <= ret + 1; k++) begin
         chk("nextFSM", nextFSM, (k == 1) ? exp_sel : 7'b0000000);
         chk("insDone", insDone, k == ret);
         chk("insReady", insReady, k == ret + 1);
         chk("wER", wER, (k >= 2 && k <= ret) ? pw : 4'b0000);
         chk("rER", rER, (k >= 2 && k <= ret) ? pr : 4'b0000);
         chk("errFlag", errFlag, 1'b0);
         if (k <= ret) begin
            // Done during launch/blank is stale and must be ignored
            if (k <= 1 + BLANK) dn = 1'($urandom_range(0, 1));
            else                dn = (k == 2 + BLANK + dly);
            drive(idx, dn);
            pw = wer_in[idx];
            pr = rer_in[idx];
            tick();
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed hang expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] op;
      rst = 1'b1;
      insValid = 1'b0;
      opCode = 4'b0000;
      drive_quiet();
      tick();
      do_reset();

      // Move, then ALU with stale done and one extra WAIT cycle
      run_instr(4'b1010, 0);
      run_instr(4'b0001, 1);

      // Random legal instruction stream
      for (int n = 0; n < 24; n++) begin
         op = 4'($urandom_range(1, 13));
         run_instr(op, $urandom_range(0, 5));
      end

      // Foreign FSM drives the bus during a Load's blank window
      launch(4'b1100, 2);
      drive(3, 1'b0);
      wer_in[4] = 4'b0010;
      tick();
      chk("conf_errFlag", errFlag, 1'b1);
      chk("conf_wER", wER, 4'b0000);
      chk("conf_nextFSM", nextFSM, 7'b1111111);
      chk("conf_insReady", insReady, 1'b0);
      do_reset();

      // Illegal opcode: error is sticky until reset
      insValid = 1'b1;
      opCode   = 4'b1110;
      tick();
      insValid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("ill_errFlag", errFlag, 1'b1);
         chk("ill_nextFSM", nextFSM, 7'b1111111);
         chk("ill_wER", wER, 4'b0000);
         chk("ill_insReady", insReady, 1'b0);
         drive(k, 1'b1);
         tick();
      end
      do_reset();

      // Done and an all-ones enable together in WAIT: error wins
      launch(4'b0011, 2 + BLANK);
      drive(0, 1'b1);
      wer_in[0] = 4'b1111;
      tick();
      chk("prio_errFlag", errFlag, 1'b1);
      chk("prio_insDone", insDone, 1'b0);
      do_reset();

      // Reset in WAIT aborts; a Movi then dispatches normally
      launch(4'b1101, 3 + BLANK);
      rst = 1'b1;
      drive_quiet();
      tick();
      chk("abort_nextFSM", nextFSM, 7'b0000000);
      chk("abort_insReady", insReady, 1'b1);
      rst = 1'b0;
      run_instr(4'b1011, 2);

      // Store whose done never arrives
      launch(4'b1101, 2 + BLANK);
`ifdef DISPATCH_WATCHDOG_EN
      for (int k = 0; k < TO; k++) begin
         chk("wd_quiet", errFlag, 1'b0);
         drive(4, 1'b0);
         tick();
      end
      chk("wd_errFlag", errFlag, 1'b1);
      chk("wd_nextFSM", nextFSM, 7'b1111111);
      do_reset();
`else
      for (int k = 0; k < 200; k++) begin
         drive(4, 1'b0);
         tick();
      end
      chk("nowd_errFlag", errFlag, 1'b0);
      chk("nowd_insReady", insReady, 1'b0);
      drive(4, 1'b1);
      tick();
      chk("nowd_insDone", insDone, 1'b1);
      drive_quiet();
      tick();
      chk("nowd_idle", insReady, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
